// File: rtl/inst_fetcher.sv
// inst_fetcher: single-outstanding instruction fetch FSM feeding the decode stage
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        issue_ready,
  input  logic        pc_change_flag,
  input  logic [31:0] pc_change_value,
  input  logic        flush,
  input  logic [31:0] flush_pc
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;
  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        fetch_ready_q;
  logic        pending;
  // request is live in IDLE/WAIT but suppressed while reset is held
  always_comb begin
    icache_req_valid = !rst_in && (state_q == IDLE || state_q == WAIT);
    icache_req_addr  = icache_req_valid ? fetch_pc_q : 32'h0;
    fetch_ready      = fetch_ready_q;
    inst             = inst_q;
    pc               = pc_q;
    pending          = (state_q == WAIT || state_q == DISCARD) && !icache_resp_valid;
  end
  // fetch FSM: flush overrides everything; an unanswered request turns into a discard
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inst_q        <= 32'h0;
      pc_q          <= 32'h0;
      fetch_ready_q <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        fetch_pc_q    <= flush_pc;
        fetch_ready_q <= 1'b0;
        state_q       <= pending ? DISCARD : IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT;
          WAIT: if (icache_resp_valid) begin
            inst_q        <= icache_resp_inst;
            pc_q          <= fetch_pc_q;
            fetch_ready_q <= 1'b1;
            state_q       <= HOLD;
          end
          HOLD: if (issue_ready) begin
            fetch_pc_q    <= pc_change_flag ? pc_change_value : pc_q + 32'd4;
            fetch_ready_q <= 1'b0;
            state_q       <= IDLE;
          end
          DISCARD: if (icache_resp_valid) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed checks of the fetch FSM against hand-computed values
module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic        fetch_ready;
  logic [31:0] inst, pc;
  logic        issue_ready, pc_change_flag, flush;
  logic [31:0] pc_change_value, flush_pc;
  int errors = 0;
  int checks = 0;

  inst_fetcher dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
    .fetch_ready(fetch_ready), .inst(inst), .pc(pc),
    .issue_ready(issue_ready), .pc_change_flag(pc_change_flag),
    .pc_change_value(pc_change_value), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // from IDLE: request, two waiting cycles, response, then HOLD
  task automatic fetch(input logic [31:0] a, input logic [31:0] w);
    chk("req_valid_idle", {31'h0, icache_req_valid}, 32'h1);
    chk("req_addr_idle", icache_req_addr, a);
    tick;
    chk("req_addr_wait", icache_req_addr, a);
    tick;
    chk("req_valid_wait", {31'h0, icache_req_valid}, 32'h1);
    icache_resp_valid = 1'b1;
    icache_resp_inst  = w;
    tick;
    icache_resp_valid = 1'b0;
    icache_resp_inst  = 32'h0;
    chk("fetch_ready_hold", {31'h0, fetch_ready}, 32'h1);
    chk("inst_hold", inst, w);
    chk("pc_hold", pc, a);
    chk("req_valid_hold", {31'h0, icache_req_valid}, 32'h0);
  endtask

  task automatic consume(input logic f, input logic [31:0] v, input logic [31:0] nxt);
    issue_ready     = 1'b1;
    pc_change_flag  = f;
    pc_change_value = v;
    tick;
    issue_ready     = 1'b0;
    pc_change_flag  = 1'b0;
    chk("fetch_ready_cleared", {31'h0, fetch_ready}, 32'h0);
    chk("next_req_addr", icache_req_addr, nxt);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    icache_resp_valid = 1'b0; icache_resp_inst = 32'h0;
    issue_ready = 1'b0; pc_change_flag = 1'b0; pc_change_value = 32'h0;
    flush = 1'b0; flush_pc = 32'h0;
    tick; tick;
    chk("rst_req_valid", {31'h0, icache_req_valid}, 32'h0);
    chk("rst_req_addr", icache_req_addr, 32'h0);
    chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    rst_in = 1'b0;
    #1;
    // sequential fetch
    fetch(32'h0, 32'hA000_0000); consume(1'b0, 32'h0, 32'h4);
    fetch(32'h4, 32'hA000_0004); consume(1'b0, 32'h0, 32'h8);
    fetch(32'h8, 32'hA000_0008); consume(1'b0, 32'h0, 32'hC);
    fetch(32'hC, 32'hA000_000C); consume(1'b0, 32'h0, 32'h10);
    fetch(32'h10, 32'hA000_0010);
    // redirect held off by backpressure, then honoured
    pc_change_flag = 1'b1; pc_change_value = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_fetch_ready", {31'h0, fetch_ready}, 32'h1);
      chk("bp_pc", pc, 32'h10);
      chk("bp_inst", inst, 32'hA000_0010);
      chk("bp_req_valid", {31'h0, icache_req_valid}, 32'h0);
    end
    consume(1'b1, 32'h100, 32'h100);
    fetch(32'h100, 32'hB000_0100); consume(1'b1, 32'h20, 32'h20);
    // flush while the 0x20 request is outstanding
    tick;
    flush = 1'b1; flush_pc = 32'h400;
    tick;
    flush = 1'b0;
    chk("discard_req_valid", {31'h0, icache_req_valid}, 32'h0);
    chk("discard_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    tick;
    chk("discard_hold", {31'h0, icache_req_valid}, 32'h0);
    icache_resp_valid = 1'b1; icache_resp_inst = 32'hDEAD_0020;
    tick;
    icache_resp_valid = 1'b0;
    chk("dropped_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("dropped_inst", inst, 32'hB000_0100);
    chk("after_flush_addr", icache_req_addr, 32'h400);
    // all events at once in HOLD: flush wins
    fetch(32'h400, 32'hC000_0400);
    flush = 1'b1; flush_pc = 32'h800;
    issue_ready = 1'b1; pc_change_flag = 1'b1; pc_change_value = 32'h900;
    icache_resp_valid = 1'b1; icache_resp_inst = 32'hDEAD_BEEF;
    tick;
    flush = 1'b0; issue_ready = 1'b0; pc_change_flag = 1'b0; icache_resp_valid = 1'b0;
    chk("simul_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("simul_req_valid", {31'h0, icache_req_valid}, 32'h1);
    chk("simul_addr", icache_req_addr, 32'h800);
    chk("simul_inst", inst, 32'hC000_0400);
    // stall mid-WAIT
    tick;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_req_valid", {31'h0, icache_req_valid}, 32'h1);
      chk("stall_addr", icache_req_addr, 32'h800);
      chk("stall_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    end
    rdy_in = 1'b1;
    icache_resp_valid = 1'b1; icache_resp_inst = 32'hD000_0800;
    tick;
    icache_resp_valid = 1'b0;
    chk("post_stall_inst", inst, 32'hD000_0800);
    chk("post_stall_pc", pc, 32'h800);
    consume(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'hE000_FFFC);
    rdy_in = 1'b0; issue_ready = 1'b1;
    tick;
    chk("stall_hold_ready", {31'h0, fetch_ready}, 32'h1);
    rdy_in = 1'b1;
    consume(1'b0, 32'h0, 32'h0);
    // asynchronous reset with a request outstanding
    tick;
    #2 rst_in = 1'b1;
    #1;
    chk("async_req_valid", {31'h0, icache_req_valid}, 32'h0);
    chk("async_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_inst", inst, 32'h0);
    tick;
    rst_in = 1'b0;
    #1;
    chk("rerst_req_valid", {31'h0, icache_req_valid}, 32'h1);
    chk("rerst_addr", icache_req_addr, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
